// File: rtl/pdm_cic_decim.sv
// PDM-to-PCM receiver: generates the PDM bit clock, samples the 1-bit stream
// once per bit and decimates it through a STAGES-order CIC filter (ratio
// 2^DECIM_LOG2). The output is unsigned offset-binary by default; define
// PDM_SIGNED_OUT_EN for a two's-complement output (MSB inverted).
module pdm_cic_decim #(
    parameter int STAGES     = 4,
    parameter int DECIM_LOG2 = 4,
    parameter int CLK_DIV    = 4,
    parameter int OUT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             pdm_clk,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid
);

    localparam int W     = STAGES * DECIM_LOG2 + 1;
    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int SHIFT = W - 1 - OUT_W;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
    localparam logic [W-1:0]    Y_MAX   = {1'b0, {(W-1){1'b1}}};

    logic [PH_W-1:0]       ph;
    logic [DECIM_LOG2-1:0] dc;
    logic                  strobe;
    logic                  decim;

    logic [W-1:0]      integ  [STAGES];
    logic [W-1:0]      data_p [STAGES];
    logic [W-1:0]      dly    [STAGES];
    logic [W-1:0]      diff   [STAGES];
    logic [STAGES-1:0] vld_p;

    // Clamp the single full-scale code R^N, drop to OUT_W bits, optionally
    // convert to two's complement.
    function automatic logic [OUT_W-1:0] sat_fmt(input logic [W-1:0] y);
        logic [W-1:0]     ys;
        logic [OUT_W-1:0] r;
        ys = (y > Y_MAX) ? Y_MAX : y;
        r  = OUT_W'(ys >> SHIFT);
`ifdef PDM_SIGNED_OUT_EN
        r[OUT_W-1] = ~r[OUT_W-1];
`endif
        return r;
    endfunction

    assign pdm_clk = en && (ph >= PH_HALF);
    assign strobe  = en && (ph == PH_LAST);
    assign decim   = strobe && (dc == '1);

    // Bit-clock phase counter; parked at 0 while disabled so a restart begins a fresh bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= '0;
        end else if (!en || ph == PH_LAST) begin
            ph <= '0;
        end else begin
            ph <= ph + PH_W'(1);
        end
    end

    // Integrator cascade and decimation counter, advancing once per PDM bit.
    // Integrators wrap modulo 2^W by design; the combs undo the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc <= '0;
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (!en) begin
            dc <= '0;
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (strobe) begin
            dc       <= dc + DECIM_LOG2'(1);
            integ[0] <= integ[0] + W'(pdm_in);
            for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Comb differences for every stage of the pipeline.
    always_comb begin
        for (int k = 0; k < STAGES; k++) diff[k] = data_p[k] - dly[k];
    end

    // Comb pipeline, one stage per clk; the last stage feeds the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k] <= '0;
                dly[k]    <= '0;
            end
        end else if (!en) begin
            // Anything in flight is discarded; dout keeps its last sample.
            vld_p      <= '0;
            dout_valid <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k] <= '0;
                dly[k]    <= '0;
            end
        end else begin
            // p0: latch the decimated integrator output
            vld_p[0] <= decim;
            if (decim) data_p[0] <= integ[STAGES-1];
            // p1..pN-1: comb stages, each touched only by its own sample
            for (int k = 0; k < STAGES; k++) begin
                if (vld_p[k]) dly[k] <= data_p[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) data_p[k] <= diff[k-1];
            end
            // pN: final comb, saturate and register the output
            dout_valid <= vld_p[STAGES-1];
            if (vld_p[STAGES-1]) dout <= sat_fmt(diff[STAGES-1]);
        end
    end

endmodule

// File: doc/pdm_cic_decim.md
Name: pdm_cic_decim

Overview:
PDM-to-PCM receiver, the inverse of the existing PCM-to-PDM path driven by `din`/`clk_out_pdm`. Generates the PDM bit clock, samples a 1-bit PDM stream and decimates it through an N-stage CIC filter. Emits unsigned OUT_W-bit PCM samples with a one-cycle valid strobe. Sits between an external PDM source (mic or loopback of `clk_out_pdm` data) and PCM consumers.

Parameters:
STAGES, 4, number of CIC integrator/comb stages (N); 1..6
DECIM_LOG2, 4, log2 of decimation ratio R (R = 2^DECIM_LOG2, default 16)
CLK_DIV, 4, clk cycles per PDM bit; even, >= 2
OUT_W, 8, PCM output width; <= STAGES*DECIM_LOG2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  run enable; low = idle and clear pipeline state
pdm_clk  output  1  generated PDM bit clock
pdm_in  input  1  PDM data bit from the source
dout  output  OUT_W  decimated PCM sample, held between strobes
dout_valid  output  1  one-cycle pulse when dout updates

Behaviour:
- One clock domain (`clk`). `reset` is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: pdm_clk=0, dout=0, dout_valid=0, all counters, integrators and comb delays =0.
- Phase counter `ph` runs 0..CLK_DIV-1 and wraps. pdm_clk = 1 when ph >= CLK_DIV/2, else 0.
- Sample strobe fires on the cycle ph==CLK_DIV-1. pdm_in is registered there, mapped to x = 1 or 0.
- Internal width W = STAGES*DECIM_LOG2 + 1 bits, unsigned modular.
- Integrators: all STAGES update on each strobe as a cascade: I1 += x, Ik += I(k-1) old value. Wrap-around is intended and must not be guarded.
- Decimation counter `dc` runs 0..R-1 and advances on each strobe. On the strobe with dc==R-1, the last integrator value is latched into the comb pipeline.
- Combs are pipelined, one stage per clk: Ck = in - delay_k, then delay_k = in. Each stage updates only for the sample being processed.
- Result y is W bits, range 0..R^N inclusive.
- dout = min(y, 2^(W-1)-1) >> (W-1-OUT_W). The saturation catches the all-ones input case, R^N.
- Latency: dout/dout_valid are registered STAGES+1 clk after the decimating strobe. dout_valid is high for exactly one clk.
- Output rate: one sample per R*CLK_DIV clk.
- Settling: the first STAGES outputs after reset or en rise are transient. Outputs from the (STAGES+1)th onward are exact.
- en=0:
  - ph, dc, integrators, comb delays and the comb pipeline are cleared.
  - pdm_clk is held 0 and no strobes or valids fire.
  - dout holds its last value.
  - en rising restarts at ph=0.
- en falling while the comb pipeline is in flight: the pending sample is dropped and no dout_valid is issued.
- Reset mid-operation: immediate clear; the first valid after release follows the normal schedule.

Optional Feature:
PDM_SIGNED_OUT_EN
- Defined: dout is two's complement, i.e. the MSB of the unsigned result is inverted. Mid-scale (1010... input) reads 0; all-ones reads 2^(OUT_W-1)-1; all-zeros reads -2^(OUT_W-1).
- Undefined: unsigned offset-binary output as above.
- Timing and valid behaviour are identical in both builds.

Test Plan:
- Reset while toggling, defaults: dout=0, dout_valid=0, pdm_clk=0. Then pdm_clk period is 4 clk, 50% duty, and dout_valid pulses every 64 clk.
- pdm_in constant 1, defaults, unsigned: after 4 settling outputs dout=255 every sample. Signed build: 127.
- pdm_in constant 0: dout=0 after settling. Signed build: -128 (0x80).
- pdm_in alternating 1,0 per PDM bit: dout=128 after settling (y=32768). Signed build: 0.
- Latency: strobe with dc==15 at clk T, so dout_valid at T+5. Drop en at T+2: no dout_valid, dout unchanged, pdm_clk low next cycle.
- Pattern 3-of-4 ones (1,1,1,0 repeating): y=49152, so dout=192 after settling. Then assert reset mid-frame: all outputs 0 within the same cycle.
